// File: rtl/mult_seq_ctrl_if.sv
// Operand stream in, tagged product stream out.
// The controller takes the slave side, the fetch/accumulator side the master.
interface mult_seq_ctrl_if #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 16
);
  logic                    in_valid;
  logic signed [W_IN-1:0]  in_data;
  logic                    in_ready;
  logic                    res_valid;
  logic signed [W_OUT-1:0] res_data;
  logic [1:0]              res_row;
  logic [2:0]              res_col;

  modport slave (
    input  in_valid, in_data,
    output in_ready, res_valid, res_data, res_row, res_col
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, res_valid, res_data, res_row, res_col
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Load/settle/read sequencer for the 2x1 by 1x3 outer-product multiplier.
// Emits the 2x3 result array row-major, one tagged product per cycle.
module mult_seq_ctrl #(
  parameter int W_IN   = 8,
  parameter int W_OUT  = 16,
  parameter int ROWS_A = 2,
  parameter int COLS_B = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  mult_seq_ctrl_if.slave          io,
  output logic                    mult_reset,
  output logic                    mult_data_in,
  output logic                    mult_mem_sel,
  output logic signed [W_IN-1:0]  mult_data,
  output logic [1:0]              mult_row_in,
  output logic [2:0]              mult_col_in,
  output logic [1:0]              mult_row_out,
  output logic [2:0]              mult_col_out,
  input  logic signed [W_OUT-1:0] mult_out,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] R_N     = 3'(ROWS_A);
  localparam logic [2:0] C_N     = 3'(COLS_B);
  localparam logic [2:0] LD_LAST = 3'(ROWS_A + COLS_B - 1);
  localparam logic [2:0] RD_LAST = 3'(ROWS_A * COLS_B - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, READ, DRAIN
  } state_t;

  state_t state, nxt;

  logic [2:0]             ld_cnt, rd_cnt;
  logic                   st_cnt;
  logic                   sh_sel;
  logic [1:0]             sh_row;
  logic [2:0]             sh_col;
  logic signed [W_IN-1:0] sh_data;
  logic                   hs, rdy;
  logic                   ld_sel;
  logic [1:0]             ld_row, rd_row;
  logic [2:0]             ld_col, rd_col;
  logic                   rv_q;
  logic [1:0]             rr_q;
  logic [2:0]             rc_q;

  assign hs     = (state == LOAD) && io.in_valid;
  assign ld_sel = ld_cnt >= R_N;
  assign ld_row = ld_sel ? 2'd0 : {1'b0, ld_cnt[0]};
  assign ld_col = ld_sel ? ld_cnt - R_N : 3'd0;
  assign rd_row = (rd_cnt >= C_N) ? 2'd1 : 2'd0;
  assign rd_col = (rd_cnt >= C_N) ? rd_cnt - C_N : rd_cnt;

  assign io.in_ready  = rdy;
  assign io.res_valid = rv_q;
  assign io.res_row   = rr_q;
  assign io.res_col   = rc_q;
  assign io.res_data  = mult_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    if (hs && ld_cnt == LD_LAST) nxt = SETTLE;
      SETTLE:  if (st_cnt) nxt = READ;
      READ:    if (rd_cnt == RD_LAST) nxt = DRAIN;
      DRAIN:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt  <= '0;
      st_cnt  <= 1'b0;
      rd_cnt  <= '0;
      sh_sel  <= 1'b0;
      sh_row  <= '0;
      sh_col  <= '0;
      sh_data <= '0;
      rv_q    <= 1'b0;
      rr_q    <= '0;
      rc_q    <= '0;
    end else begin
      rv_q <= state == READ;
      rr_q <= (state == READ) ? rd_row : 2'd0;
      rc_q <= (state == READ) ? rd_col : 3'd0;
      unique case (state)
        IDLE: ld_cnt <= '0;
        LOAD: begin
          st_cnt <= 1'b0;
          if (hs) begin
            ld_cnt  <= ld_cnt + 3'd1;
            sh_sel  <= ld_sel;
            sh_row  <= ld_row;
            sh_col  <= ld_col;
            sh_data <= io.in_data;
          end
        end
        SETTLE: begin
          st_cnt <= ~st_cnt;
          rd_cnt <= '0;
        end
        READ:    rd_cnt <= rd_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Past LOAD the last write is replayed so the array keeps recomputing.
  always_comb begin
    mult_reset   = 1'b1;
    rdy          = 1'b0;
    mult_data_in = 1'b0;
    mult_mem_sel = 1'b0;
    mult_data    = '0;
    mult_row_in  = '0;
    mult_col_in  = '0;
    mult_row_out = '0;
    mult_col_out = '0;
    busy         = state != IDLE;
    done         = 1'b0;
    unique case (state)
      LOAD: begin
        mult_reset   = 1'b0;
        rdy          = 1'b1;
        mult_data_in = io.in_valid;
        mult_mem_sel = ld_sel;
        mult_data    = io.in_data;
        mult_row_in  = ld_row;
        mult_col_in  = ld_col;
      end
      SETTLE, READ, DRAIN: begin
        mult_reset   = 1'b0;
        mult_data_in = 1'b1;
        mult_mem_sel = sh_sel;
        mult_data    = sh_data;
        mult_row_in  = sh_row;
        mult_col_in  = sh_col;
        if (state == READ) begin
          mult_row_out = rd_row;
          mult_col_out = rd_col;
        end
        done = state == DRAIN;
      end
      default: ;
    endcase
  end

endmodule
